// File: rtl/video_scaler_if.sv
// video_scaler_if: pixel stream, mode and scaled-output signals of the video scaler
interface video_scaler_if #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 8,
  parameter int CHANNELS = 3
);
  logic                         pix_ce;
  logic [1:0]                   mode_req;
  logic [1:0]                   mode_cur;
  logic [CHANNELS*IN_BITS-1:0]  din;
  logic                         active_i;
  logic                         hsync_i;
  logic                         vsync_i;
  logic [CHANNELS*OUT_BITS-1:0] dout;
  logic                         active_o;
  logic                         hsync_o;
  logic                         vsync_o;
  modport master (
    output pix_ce, mode_req, din, active_i, hsync_i, vsync_i,
    input  mode_cur, dout, active_o, hsync_o, vsync_o
  );
  modport slave (
    input  pix_ce, mode_req, din, active_i, hsync_i, vsync_i,
    output mode_cur, dout, active_o, hsync_o, vsync_o
  );
endinterface

// File: rtl/video_scaler_pipe.sv
// video_scaler_pipe: pipelined N-channel colour-depth scaler with sync alignment and frame-gated mode switch
module video_scaler_pipe #(
  parameter int IN_BITS    = 6,
  parameter int OUT_BITS   = 8,
  parameter int CHANNELS   = 3,
  parameter int LATENCY    = 3,
  parameter bit BLANK_ZERO = 1'b1,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic             clk_dot4x,
  input  logic             rst_n,
  video_scaler_if.slave    bus
);
  localparam int PW = IN_BITS + OUT_BITS + 1;
  localparam int MI = (1 << IN_BITS) - 1;
  localparam int MO = (1 << OUT_BITS) - 1;
  localparam int D  = LATENCY - 3;
  localparam int IW = CHANNELS * IN_BITS;
  localparam int OW = CHANNELS * OUT_BITS;
  // control bundle is {active, hsync, vsync}; reset leaves syncs at their inactive level
  localparam logic [2:0] CTL_RST = {1'b0, !SYNC_POL, !SYNC_POL};

  logic          w_vs_act;
  logic          w_frame_edge;
  logic          r_vs_prev;
  logic [1:0]    r_mode;
  logic [IW-1:0] r_s1_din;
  logic [1:0]    r_s1_mode;
  logic [2:0]    r_s1_ctl;
  logic [PW-1:0] w_prod [CHANNELS];
  logic [PW-1:0] r_s2_prod [CHANNELS];
  logic [OW-1:0] w_rep;
  logic [OW-1:0] r_s2_rep;
  logic [1:0]    r_s2_mode;
  logic [2:0]    r_s2_ctl;
  logic [OW-1:0] w_s3_dout;
  logic [OW-1:0] r_dq_dout [D+1];
  logic [2:0]    r_dq_ctl [D+1];

  assign w_vs_act     = (bus.vsync_i == SYNC_POL);
  assign w_frame_edge = bus.pix_ce & w_vs_act & ~r_vs_prev;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // rounding offset is folded into the product stage so stage 3 only divides
    assign w_prod[c] = PW'(r_s1_din[c*IN_BITS +: IN_BITS]) * PW'(MO)
                     + ((r_s1_mode == 2'd1) ? PW'(MI / 2) : PW'(0));
    for (genvar b = 0; b < OUT_BITS; b++) begin : g_rep
      assign w_rep[c*OUT_BITS + b] = r_s1_din[c*IN_BITS + IN_BITS - 1 - ((OUT_BITS - 1 - b) % IN_BITS)];
    end
    assign w_s3_dout[c*OUT_BITS +: OUT_BITS] = (BLANK_ZERO && !r_s2_ctl[2]) ? '0 :
                                               (r_s2_mode == 2'd2) ? r_s2_rep[c*OUT_BITS +: OUT_BITS] :
                                               OUT_BITS'(r_s2_prod[c] / PW'(MI));
  end

  // frame-edge detector and mode register; the pixel entering on the edge still sees the old mode
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev <= 1'b0;
      r_mode    <= 2'd0;
    end else if (bus.pix_ce) begin
      r_vs_prev <= w_vs_act;
      if (w_frame_edge && bus.mode_req != 2'd3) r_mode <= bus.mode_req;
    end
  end

  // stage 1: capture pixel, DE/syncs and the mode tag that travels with it
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_din  <= '0;
      r_s1_mode <= 2'd0;
      r_s1_ctl  <= CTL_RST;
    end else if (bus.pix_ce) begin
      r_s1_din  <= bus.din;
      r_s1_mode <= r_mode;
      r_s1_ctl  <= {bus.active_i, bus.hsync_i, bus.vsync_i};
    end
  end

  // stage 2: multiply/add and replication
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_s2_prod[i] <= '0;
      r_s2_rep  <= '0;
      r_s2_mode <= 2'd0;
      r_s2_ctl  <= CTL_RST;
    end else if (bus.pix_ce) begin
      for (int i = 0; i < CHANNELS; i++) r_s2_prod[i] <= w_prod[i];
      r_s2_rep  <= w_rep;
      r_s2_mode <= r_s1_mode;
      r_s2_ctl  <= r_s1_ctl;
    end
  end

  // stage 3 result plus pure-delay stages up to LATENCY
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= D; i++) begin
        r_dq_dout[i] <= '0;
        r_dq_ctl[i]  <= CTL_RST;
      end
    end else if (bus.pix_ce) begin
      r_dq_dout[0] <= w_s3_dout;
      r_dq_ctl[0]  <= r_s2_ctl;
      for (int i = 1; i <= D; i++) begin
        r_dq_dout[i] <= r_dq_dout[i-1];
        r_dq_ctl[i]  <= r_dq_ctl[i-1];
      end
    end
  end

  assign bus.dout     = r_dq_dout[D];
  assign bus.active_o = r_dq_ctl[D][2];
  assign bus.hsync_o  = r_dq_ctl[D][1];
  assign bus.vsync_o  = r_dq_ctl[D][0];
  assign bus.mode_cur = r_mode;
endmodule

// File: tb/tb_video_scaler_pipe.sv
// tb_video_scaler_pipe: randomized and directed checks of video_scaler_pipe against a queue-based model
module tb_video_scaler_pipe;
  localparam int IB  = 6;
  localparam int OB  = 8;
  localparam int CH  = 3;
  localparam int LAT = 3;
  localparam bit BZ  = 1'b1;
  localparam bit SP  = 1'b1;
  localparam int MI  = 63;
  localparam int MO  = 255;
  localparam int IW  = CH * IB;

  typedef struct {
    logic [CH*OB-1:0] d;
    logic a;
    logic h;
    logic v;
    int   lit;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  ent_t q[$];
  int   m_mode   = 0;
  bit   m_vsp    = 1'b0;
  int   lit      = -1;
  int   exp_mode = -1;
  bit   chk_en   = 1'b0;
  int   total    = 0;
  int   bad      = 0;
  logic [7:0] l8;

  always #5 clk = ~clk;

  video_scaler_if #(.IN_BITS(IB), .OUT_BITS(OB), .CHANNELS(CH)) bus();

  video_scaler_pipe #(
    .IN_BITS(IB), .OUT_BITS(OB), .CHANNELS(CH), .LATENCY(LAT),
    .BLANK_ZERO(BZ), .SYNC_POL(SP)
  ) dut (
    .clk_dot4x(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic int scale(int v, int m);
    longint acc;
    int n;
    if (m == 2) begin
      acc = 0;
      n = 0;
      while (n < OB) begin
        acc = (acc << IB) | longint'(v);
        n += IB;
      end
      return int'(acc >> (n - OB));
    end
    if (m == 1) return (v * MO + MI / 2) / MI;
    return v * MO / MI;
  endfunction

  // reference: a queue of LAT expected outputs advanced once per pix_ce beat
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < LAT; i++) q.push_back('{d: '0, a: 1'b0, h: !SP, v: !SP, lit: -1});
      m_mode = 0;
      m_vsp  = 1'b0;
    end else if (bus.pix_ce) begin
      ent_t e;
      bit   va;
      e.d = '0;
      for (int c = 0; c < CH; c++)
        e.d[c*OB +: OB] = (bus.active_i || !BZ) ? OB'(scale(int'(bus.din[c*IB +: IB]), m_mode)) : '0;
      e.a   = bus.active_i;
      e.h   = bus.hsync_i;
      e.v   = bus.vsync_i;
      e.lit = lit;
      q.push_back(e);
      void'(q.pop_front());
      va = (bus.vsync_i == SP);
      if (va && !m_vsp && bus.mode_req != 2'd3) m_mode = int'(bus.mode_req);
      m_vsp = va;
    end
  end

  task automatic cmp(string n, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("dout", 32'(bus.dout), 32'(q[0].d));
      cmp("active_o", 32'(bus.active_o), 32'(q[0].a));
      cmp("hsync_o", 32'(bus.hsync_o), 32'(q[0].h));
      cmp("vsync_o", 32'(bus.vsync_o), 32'(q[0].v));
      cmp("mode_cur", 32'(bus.mode_cur), 32'(m_mode));
      if (q[0].lit >= 0) begin
        l8 = 8'(q[0].lit);
        cmp("lit_dout", 32'(bus.dout), 32'({l8, l8, l8}));
        cmp("lit_model", 32'(q[0].d), 32'({l8, l8, l8}));
      end
      if (exp_mode >= 0) cmp("lit_mode", 32'(bus.mode_cur), 32'(exp_mode));
      if (!rst_n) begin
        cmp("rst_dout", 32'(bus.dout), 32'h0);
        cmp("rst_ctl", 32'({bus.active_o, bus.hsync_o, bus.vsync_o}), 32'({1'b0, !SP, !SP}));
      end
    end
  end

  task automatic px(input int v, input bit a, input bit vs, input bit ce, input int l);
    @(posedge clk);
    #1;
    bus.din      = {CH{IB'(v)}};
    bus.active_i = a;
    bus.hsync_i  = 1'($urandom_range(0, 1));
    bus.vsync_i  = vs ? SP : !SP;
    bus.pix_ce   = ce;
    lit          = l;
  endtask

  int vin[7] = '{0, 1, 10, 32, 33, 63, 21};
  int l0[7]  = '{0, 4, 40, 129, 133, 255, 85};
  int l1[7]  = '{0, 4, 40, 130, 134, 255, 85};

  initial begin
    bus.pix_ce   = 1'b0;
    bus.din      = '0;
    bus.active_i = 1'b0;
    bus.hsync_i  = !SP;
    bus.vsync_i  = !SP;
    bus.mode_req = 2'd0;
    #2 rst_n = 1'b0;
    chk_en   = 1'b1;
    exp_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (vin[i]) px(vin[i], 1'b1, 1'b0, 1'b1, l0[i]);
    bus.mode_req = 2'd1;
    px(32, 1'b1, 1'b0, 1'b1, 129);
    px(32, 1'b1, 1'b0, 1'b1, 129);
    exp_mode = -1;
    px(32, 1'b1, 1'b1, 1'b1, 129);
    px(32, 1'b1, 1'b1, 1'b1, 130);
    exp_mode = 1;
    foreach (vin[i]) px(vin[i], 1'b1, 1'b0, 1'b1, l1[i]);
    bus.mode_req = 2'd2;
    exp_mode = -1;
    px(32, 1'b1, 1'b1, 1'b1, 130);
    foreach (vin[i]) begin
      px(vin[i], 1'b1, 1'b0, 1'b1, l1[i]);
      exp_mode = 2;
    end
    bus.mode_req = 2'd3;
    px(21, 1'b1, 1'b1, 1'b1, 85);
    px(21, 1'b1, 1'b0, 1'b1, 85);
    for (int k = 0; k < 8; k++) begin
      px(k == 0 ? 33 : int'($urandom_range(0, MI)), 1'b1, 1'b0, 1'b1, k == 0 ? 134 : -1);
      repeat (3) begin
        px(int'($urandom_range(0, MI)), 1'($urandom), 1'($urandom), 1'b0, -1);
        bus.mode_req = 2'($urandom);
      end
    end
    px(63, 1'b0, 1'b0, 1'b1, 0);
    px(63, 1'b1, 1'b0, 1'b1, 255);
    exp_mode = -1;
    repeat (400) begin
      if ($urandom_range(0, 15) == 0) bus.mode_req = 2'($urandom);
      px(0, 1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, -1);
      bus.din = IW'($urandom);
    end
    bus.mode_req = 2'd1;
    repeat (3) px(10, 1'b1, 1'b0, 1'b1, -1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    px(32, 1'b1, 1'b0, 1'b1, 129);
    px(32, 1'b1, 1'b1, 1'b1, 129);
    px(32, 1'b1, 1'b1, 1'b1, 130);
    exp_mode = 1;
    px(32, 1'b1, 1'b0, 1'b1, 130);
    repeat (5) px(0, 1'b0, 1'b0, 1'b1, -1);
    @(posedge clk);
    #1 chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/video_scaler_pipe.md
# video_scaler_pipe

Parametrised, pipelined colour-depth scaler and sync aligner between the vicii RGB/sync outputs and any wider-colour video encoder, such as the DVI TMDS encoder. It generalises the fixed 6-to-8-bit combinational scale to N channels and arbitrary input/output widths. It offers three scaling modes that can only be switched at a frame boundary. Sync and data-enable are delayed in lockstep with the data. It runs on the dot clock and advances only on a pixel-enable strobe.

## Interface
- IN_BITS, 6, per-channel input width (≥1)
- OUT_BITS, 8, per-channel output width; must satisfy OUT_BITS ≥ IN_BITS
- CHANNELS, 3, number of colour channels; ch0 at LSBs (ch0=blue, ch1=green, ch2=red)
- LATENCY, 3, pipeline depth in pix_ce beats (≥3); stages beyond 3 are pure delay
- BLANK_ZERO, 1, 1 = force dout to 0 for pixels that enter with active_i=0
- SYNC_POL, 1, asserted level of hsync/vsync (1 = active-high)

Ports:
- clk_dot4x  in  1  dot clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pix_ce  in  1  pixel-advance strobe; pipeline holds when 0
- mode_req  in  2  requested mode: 0 = floor, 1 = rounded, 2 = bit replication, 3 = reserved
- mode_cur  out  2  mode currently applied to entering pixels
- din  in  CHANNELS*IN_BITS  packed input pixel
- active_i, hsync_i, vsync_i  in  1 each  input DE and syncs
- dout  out  CHANNELS*OUT_BITS  packed scaled pixel
- active_o, hsync_o, vsync_o  out  1 each  DE and syncs aligned with dout

## Operation
- Definitions: MI = 2^IN_BITS−1, MO = 2^OUT_BITS−1. The product intermediate is IN_BITS+OUT_BITS+1 bits wide, so it never overflows.
- Mode 0 (floor): out = floor(in·MO / MI).
- Mode 1 (rounded): out = floor((in·MO + floor(MI/2)) / MI).
- Mode 2 (replication): repeat the input bits MSB-first until OUT_BITS are filled, then truncate.
- When OUT_BITS = IN_BITS, all modes are identity.
- Stage 1 registers din, active_i, hsync_i and vsync_i, plus the mode_cur value sampled at entry (mode tag).
- Stage 2 performs the multiply/add, or forms the replication result.
- Stage 3 performs the constant divide and selects the result per the mode tag.
- Stages 4..LATENCY are delay only.
- Each in-flight pixel keeps its mode tag. A mode change never alters a pixel already in the pipe.
- Mode switch: vs_prev holds vsync_i as of the last pix_ce. When pix_ce=1 and vsync_i is asserted while vs_prev is not, mode_cur ← mode_req at the end of that cycle. The pixel entering on that same cycle uses the old mode.
- mode_req=3 at the switch point is ignored, and mode_cur is unchanged.
- Changes to mode_req between frame edges have no effect.
- Blanking: if BLANK_ZERO=1 and the pixel's entry active=0, dout=0 for that pixel. Syncs and active still propagate.
- pix_ce=0: all pipeline registers, vs_prev and mode_cur hold.

## Timing
- Latency is exactly LATENCY pix_ce beats, measured from the clk_dot4x edge that samples a pixel with pix_ce=1 to its appearance on dout and the sync outputs. Throughput is one pixel per pix_ce.
- If pix_ce is tied high, latency is LATENCY clk_dot4x cycles.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset (rst_n=0, any time, asynchronous):
  - dout=0, active_o=0, mode_cur=0.
  - hsync_o and vsync_o = ~SYNC_POL (inactive).
  - vs_prev = inactive.
  - All in-flight pixels are discarded.
- After reset, the first pix_ce with vsync_i asserted counts as a frame edge.
- Release of rst_n is expected synchronous to clk_dot4x. The block adds no internal reset synchroniser.
- Consecutive pix_ce edges on vsync (vsync pulse of one beat) each trigger one mode load.

## Test plan
- Mode 0, IN=6/OUT=8, pix_ce=1: din ch values 0, 1, 10, 32, 33, 63 -> dout 0, 4, 40, 129, 133, 255 exactly 3 cycles later.
- Mode 1 (loaded via vsync edge), same inputs -> 0, 4, 40, 130, 134, 255. Mode 2 -> 0, 4, 40, 130, 134, 255; in=21 -> 85 in all modes.
- Frame-boundary switch: set mode_req=1 mid-frame -> mode_cur stays 0 until the first pix_ce with a vsync rising edge, then becomes 1. Pixels entering before and on the edge cycle scale per mode 0 (in=32 -> 129); the next pixel gives 130. mode_req=3 at an edge -> mode_cur unchanged.
- pix_ce pattern 1-0-0-0 (one beat in 4): the pixel sampled on beat k emerges on beat k+3. Outputs hold between beats, and syncs stay aligned with dout.
- BLANK_ZERO=1: din=all 63 with active_i=0 -> dout=0, active_o=0 after LATENCY. With active_i=1 -> dout=all 255.
- Assert rst_n=0 mid-stream with 3 pixels in flight -> outputs go to reset values immediately without a clock edge. After release, no stale pixel appears, mode_cur=0, and the first asserted vsync beat loads mode_req.
